// File: rtl/cpu_writeback_regfile.sv
// -----------------------------------------------------------------------------
// cpu_writeback_regfile
//
// Purpose:
//   Writeback stage plus architectural register file. After reset, a CLEAR
//   sweep zeroes one register per cycle. The sweep lasts NREGS cycles. When it
//   completes, the file enters RUN. In RUN it accepts commit-stage writes and
//   returns the register contents on two combinational read ports. The stage
//   also gives the forwarding unit the destination, write-valid and write value,
//   and counts the register writes it commits.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset (restarts the CLEAR sweep)
//   wb_reg_write   writeback request from the commit stage
//   wb_mem_to_reg  write source select: 1 = wb_mem_data, 0 = wb_alu_data
//   wb_alu_data    ALU result
//   wb_mem_data    load data
//   wb_reg_dest    destination register index
//   rs1_addr/rs2_addr  decode-stage read indices
//   rs1_data/rs2_data  read data (0 during CLEAR and for register 0)
//   rd_wb          destination index to the forwarding unit
//   writeback_wb   forwarding-unit write-valid
//   wb_value       forwarding-unit write value
//   rf_ready       1 once the CLEAR sweep has finished
//   write_count    number of committed register writes (wraps)
//
// Configuration:
//   CPU_WB_BYPASS_EN  when defined, a read that hits the register being written
//                     in the same cycle returns the new value (write-through).
//                     When it is undefined, the read returns the array contents,
//                     and the new value appears the cycle after the write edge.
// -----------------------------------------------------------------------------
module cpu_writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_reg_write,
    input  logic            wb_mem_to_reg,
    input  logic [XLEN-1:0] wb_alu_data,
    input  logic [XLEN-1:0] wb_mem_data,
    input  logic [AW-1:0]   wb_reg_dest,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [AW-1:0]   rd_wb,
    output logic            writeback_wb,
    output logic [XLEN-1:0] wb_value,
    output logic            rf_ready,
    output logic [31:0]     write_count
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_clear_idx;
    logic [AW-1:0]   w_clear_idx_next;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_write_count;

    logic            w_ready;
    logic            w_wb_valid;
    logic [XLEN-1:0] w_wb_value;
    logic            w_rs1_bypass;
    logic            w_rs2_bypass;

    // Writeback mux and forwarding outputs
    assign w_wb_value   = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
    assign w_ready      = (r_state == ST_RUN);
    assign w_wb_valid   = wb_reg_write & w_ready & (wb_reg_dest != '0);

    assign wb_value     = w_wb_value;
    assign rd_wb        = wb_reg_dest;
    assign writeback_wb = w_wb_valid;
    assign rf_ready     = w_ready;
    assign write_count  = r_write_count;

    // Next-state logic. The sweep advances one index per cycle. It leaves
    // CLEAR on the edge that clears the last index.
    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        case (r_state)
            ST_CLEAR: begin
                w_clear_idx_next = r_clear_idx + AW'(1);
                if (r_clear_idx == AW'(NREGS - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_idx <= w_clear_idx_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_write_count <= '0;
        end else if (w_wb_valid) begin
            r_write_count <= r_write_count + 32'd1;
        end
    end

    // The array has no reset of its own; the CLEAR sweep zeroes it. A write
    // that coincides with reset is dropped. writeback_wb can still be high
    // when reset arrives during RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_clear_idx] <= '0;
            end else if (w_wb_valid) begin
                r_regs[wb_reg_dest] <= w_wb_value;
            end
        end
    end

`ifdef CPU_WB_BYPASS_EN
    assign w_rs1_bypass = w_wb_valid & (rs1_addr == wb_reg_dest);
    assign w_rs2_bypass = w_wb_valid & (rs2_addr == wb_reg_dest);
`else
    assign w_rs1_bypass = 1'b0;
    assign w_rs2_bypass = 1'b0;
`endif

    // Each read port resolves on its own. Register 0 and every read during
    // CLEAR return 0, whatever the array holds.
    assign rs1_data = (!w_ready || rs1_addr == '0) ? '0 :
                      w_rs1_bypass                 ? w_wb_value :
                                                     r_regs[rs1_addr];
    assign rs2_data = (!w_ready || rs2_addr == '0) ? '0 :
                      w_rs2_bypass                 ? w_wb_value :
                                                     r_regs[rs2_addr];

endmodule

// File: tb/tb_cpu_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_cpu_writeback_regfile
//
// Purpose:
//   Self-checking bench for cpu_writeback_regfile with default parameters.
//   A behavioural model tracks the contents of each register, the number of
//   cycles since reset and the write count. Every cycle, all DUT outputs are
//   compared with that model. Directed scenarios add fixed-value checks, and
//   a randomized run follows them.
// -----------------------------------------------------------------------------
module tb_cpu_writeback_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            wb_reg_write = 1'b0;
    logic            wb_mem_to_reg = 1'b0;
    logic [XLEN-1:0] wb_alu_data = '0;
    logic [XLEN-1:0] wb_mem_data = '0;
    logic [AW-1:0]   wb_reg_dest = '0;
    logic [AW-1:0]   rs1_addr = '0;
    logic [AW-1:0]   rs2_addr = '0;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   rd_wb;
    logic            writeback_wb;
    logic [XLEN-1:0] wb_value;
    logic            rf_ready;
    logic [31:0]     write_count;

    cpu_writeback_regfile #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_reg_write (wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_data  (wb_alu_data),
        .wb_mem_data  (wb_mem_data),
        .wb_reg_dest  (wb_reg_dest),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_wb        (rd_wb),
        .writeback_wb (writeback_wb),
        .wb_value     (wb_value),
        .rf_ready     (rf_ready),
        .write_count  (write_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [NREGS];
    int unsigned m_cycles_since_reset = 0;
    logic [31:0] m_count = '0;
    bit          m_valid = 1'b0;

    // Observations from the latest cycle, kept for the directed checks
    logic [31:0] obs_rs1, obs_rs2, obs_count;
    logic        obs_ready, obs_wb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [AW-1:0] addr, input bit ready,
                                             input bit wvalid, input logic [AW-1:0] dest,
                                             input logic [31:0] val);
        if (!ready || addr == 0) return 32'd0;
`ifdef CPU_WB_BYPASS_EN
        if (wvalid && addr == dest) return val;
`endif
        return m_regs[addr];
    endfunction

    // One clock cycle: drive after the falling edge, check, then advance the
    // model at the rising edge.
    task automatic cyc(input bit rst, input bit wr, input bit m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [AW-1:0] dest, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
        bit          e_ready, e_wb;
        logic [31:0] e_val;
        @(negedge clock);
        reset = rst; wb_reg_write = wr; wb_mem_to_reg = m2r;
        wb_alu_data = alu; wb_mem_data = mem; wb_reg_dest = dest;
        rs1_addr = a1; rs2_addr = a2;
        #1;
        e_ready = (m_cycles_since_reset >= NREGS);
        e_val   = m2r ? mem : alu;
        e_wb    = wr && e_ready && (dest != 0);
        chk("wb_value", wb_value, e_val);
        chk("rd_wb", rd_wb, dest);
        if (m_valid) begin
            chk("rf_ready", rf_ready, e_ready);
            chk("writeback_wb", writeback_wb, e_wb);
            chk("rs1_data", rs1_data, ref_read(a1, e_ready, e_wb, dest, e_val));
            chk("rs2_data", rs2_data, ref_read(a2, e_ready, e_wb, dest, e_val));
            chk("write_count", write_count, m_count);
        end
        obs_rs1 = rs1_data; obs_rs2 = rs2_data; obs_count = write_count;
        obs_ready = rf_ready; obs_wb = writeback_wb;
        @(posedge clock);
        if (rst) begin
            m_cycles_since_reset = 0;
            m_count = '0;
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_valid = 1'b1;
        end else if (m_cycles_since_reset < NREGS) begin
            m_cycles_since_reset++;
        end else if (e_wb) begin
            m_regs[dest] = e_val;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, a1, a2);
    endtask

    // Counts the cycles with rf_ready low and stops at the first high
    // cycle. The loop is bounded, so a stuck FSM still ends the run.
    task automatic sweep_len(input string tag);
        int lows = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 3 * NREGS && !seen; i++) begin
            idle(5'(i), 5'(i + 1));
            if (obs_ready) seen = 1'b1;
            else lows++;
        end
        chk(tag, lows, NREGS);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

        // Reset sweep
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        sweep_len("sweep_len_initial");
        chk("count_after_reset", obs_count, 32'd0);
        $display("scenario reset_sweep done");

        // ALU and load writes
        cyc(0, 1, 0, 32'hDEADBEEF, 32'h0, 5'd5, 0, 0);
        cyc(0, 1, 1, 32'h0, 32'h12345678, 5'd6, 0, 0);
        idle(5'd5, 5'd6);
        chk("r5_alu", obs_rs1, 32'hDEADBEEF);
        chk("r6_mem", obs_rs2, 32'h12345678);
        chk("count_two", obs_count, 32'd2);
        $display("scenario alu_vs_load done");

        // r0 protection
        cyc(0, 1, 0, 32'hFFFFFFFF, 32'h0, 5'd0, 0, 0);
        chk("r0_wb_valid", obs_wb, 1'b0);
        idle(5'd0, 5'd0);
        chk("r0_read", obs_rs1, 32'd0);
        chk("r0_count", obs_count, 32'd2);
        $display("scenario r0_protect done");

        // Same-cycle read of r7
        cyc(0, 1, 0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7);
`ifdef CPU_WB_BYPASS_EN
        chk("r7_same_rs1", obs_rs1, 32'hA5A5A5A5);
        chk("r7_same_rs2", obs_rs2, 32'hA5A5A5A5);
`else
        chk("r7_same_rs1", obs_rs1, 32'd0);
        chk("r7_same_rs2", obs_rs2, 32'd0);
`endif
        idle(5'd7, 5'd7);
        chk("r7_next_rs1", obs_rs1, 32'hA5A5A5A5);
        chk("r7_next_rs2", obs_rs2, 32'hA5A5A5A5);
        $display("scenario same_cycle_read done");

        // A write presented during CLEAR is dropped
        cyc(0, 1, 0, 32'h55, 32'h0, 5'd3, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) idle(0, 0);
        cyc(0, 1, 0, 32'h55, 32'h0, 5'd3, 5'd3, 0);
        chk("clear_write_wb", obs_wb, 1'b0);
        for (int i = 0; i < NREGS; i++) idle(0, 0);
        idle(5'd3, 5'd3);
        chk("r3_dropped", obs_rs1, 32'd0);
        chk("clear_count", obs_count, 32'd0);
        $display("scenario write_during_clear done");

        // Reset during RUN with a concurrent write
        cyc(0, 1, 0, 32'h1, 32'h0, 5'd1, 0, 0);
        idle(5'd1, 0);
        chk("r1_loaded", obs_rs1, 32'h1);
        cyc(1, 1, 0, 32'h77, 32'h0, 5'd2, 0, 0);
        sweep_len("sweep_len_midrun");
        idle(5'd1, 5'd2);
        chk("r1_cleared", obs_rs1, 32'd0);
        chk("r2_dropped", obs_rs2, 32'd0);
        $display("scenario reset_mid_run done");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] d, a1, a2;
            d  = 5'($urandom_range(0, NREGS - 1));
            a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, NREGS - 1));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, NREGS - 1));
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 1)), $urandom, $urandom, d, a1, a2);
        end
        $display("scenario random done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
